restoring_divider: RTL

- Sequential signed restoring divider for the multiply/divide/root (MDR) unit. It is the inverse operation to the Booth multiplier.
- Takes a DW-bit two's-complement dividend and divisor on a start pulse. Returns a truncated-toward-zero quotient and a remainder.
- Handshake is start/ready, driven by the same top-level MDR control FSM that drives the multiplier.
- Operates on magnitudes, one quotient bit per clock, then applies sign correction.

---
 rtl/mdr_pkg.sv | 16 +
 rtl/restoring_divider_if.sv | 26 ++
 rtl/restoring_divider_div_iter_counter.sv | 36 +++
 rtl/restoring_divider.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared constants and types for the multiply/divide/root unit.
package mdr_pkg;

  localparam int unsigned DW     = 16;
  localparam int unsigned DW_DBL = 2 * DW;
  localparam int unsigned CW     = $clog2(DW);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/restoring_divider_if.sv
// Start/ready handshake and result bus between the MDR control FSM and the divider.
interface restoring_divider_if #(
  parameter int unsigned DW = mdr_pkg::DW
) ();

  logic          start;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          busy;
  logic          ready;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, ready, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, ready, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/restoring_divider_div_iter_counter.sv
// Iteration counter for the divider: sync clear, enable, terminal count at DW-1.
module div_iter_counter #(
  parameter int unsigned DW = mdr_pkg::DW,
  parameter int unsigned CW = $clog2(DW)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins over enable.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CW'(DW - 1));

endmodule

// File: rtl/restoring_divider.sv
// Sequential signed restoring divider: magnitudes, one quotient bit per clock, then sign fix.
module restoring_divider #(
  parameter int unsigned DW = mdr_pkg::DW
) (
  input logic                clk,
  input logic                rst,
  restoring_divider_if.slave bus
);

  import mdr_pkg::*;

  localparam int unsigned WW = 2 * DW + 1;
  localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW - 1){1'b0}}};

  div_state_e    state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] dvs_mag_q, dvs_mag_d;
  logic [WW-1:0] work_q, work_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic          cnt_en, cnt_clr, cnt_tc;
  logic [DW-1:0] dvd_mag, dvs_mag, q_mag, r_mag;
  logic [WW-1:0] shifted;
  logic [DW:0]   trial;

  div_iter_counter #(
    .DW (DW),
    .CW ($clog2(DW))
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .tc  (cnt_tc)
  );

  // Next-state and datapath: FSM sequencing, restoring step and sign correction.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    dvs_mag_d = dvs_mag_q;
    work_d    = work_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;

    dvd_mag = dvd_q[DW-1] ? (~dvd_q + 1'b1) : dvd_q;
    dvs_mag = dvs_q[DW-1] ? (~dvs_q + 1'b1) : dvs_q;
    shifted = work_q << 1;
    trial   = shifted[WW-1:DW] - {1'b0, dvs_mag_q};
    q_mag   = work_q[DW-1:0];
    r_mag   = work_q[2*DW-1:DW];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        work_d    = {{(DW + 1){1'b0}}, dvd_mag};
        dvs_mag_d = dvs_mag;
        qneg_d    = dvd_q[DW-1] ^ dvs_q[DW-1];
        rneg_d    = dvd_q[DW-1];
        dbz_d     = 1'b0;
        ovf_d     = 1'b0;
        cnt_clr   = 1'b1;
        if (dvs_q == '0) begin
          dbz_d   = 1'b1;
          quot_d  = '1;
          rem_d   = dvd_q;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end else if (dvd_q == MIN_VAL && dvs_q == '1) begin
          ovf_d   = 1'b1;
          quot_d  = MIN_VAL;
          rem_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        // Keep the subtraction only when the partial remainder stays non-negative.
        if (!trial[DW]) begin
          work_d = {trial, shifted[DW-1:1], 1'b1};
        end else begin
          work_d = shifted;
        end
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quot_d  = qneg_q ? (~q_mag + 1'b1) : q_mag;
        rem_d   = rneg_q ? (~r_mag + 1'b1) : r_mag;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      dvs_mag_q <= '0;
      work_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      dvs_mag_q <= dvs_mag_d;
      work_q    <= work_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.ready       = ready_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule
